// File: rtl/pc_ctl.sv
// -----------------------------------------------------------------------------
// pc_ctl -- program-counter / instruction-fetch front end.
//
// Issues one instruction fetch at a time and presents the fetched word to
// decode. Branch and trap redirects restart the fetch stream at a new
// address. A redirect pulses flush for one cycle. An outstanding fetch is
// never withdrawn. If a redirect arrives while a fetch is in flight, the
// fetch is allowed to complete and its data is discarded.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   trap_en      trap/mret redirect request (has priority over br_en)
//   trap_pc      trap/mret target address
//   br_en        branch/jump redirect request
//   br_pc        branch/jump target address
//   stall        decode cannot accept the presented instruction
//   if_req       fetch request, held until if_ack
//   if_addr      fetch address, stable while if_req is high
//   if_ack       fetch complete, if_rdata valid this cycle
//   if_rdata     fetched instruction word
//   inst_valid   inst / inst_pc valid toward decode
//   inst         instruction to decode
//   inst_pc      address of inst
//   flush        one-cycle pulse after every redirect
//
// Build option:
//   TRAP_PC_ALIGN_EN  when defined, bits [1:0] of the redirect target are
//                     cleared before the target is loaded.
// -----------------------------------------------------------------------------
module pc_ctl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_en,
    input  logic [63:0] trap_pc,
    input  logic        br_en,
    input  logic [63:0] br_pc,
    input  logic        stall,
    output logic        if_req,
    output logic [63:0] if_addr,
    input  logic        if_ack,
    input  logic [31:0] if_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        flush
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        REQ     = 2'd1,
        VALID   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pc_reg, pc_next;
    logic [63:0] req_addr_reg, req_addr_next;
    logic [31:0] inst_reg, inst_next;
    logic [63:0] inst_pc_reg, inst_pc_next;
    logic        flush_reg;

    logic        redirect;
    logic [63:0] target_raw;
    logic [63:0] target;

    assign redirect   = trap_en | br_en;
    assign target_raw = trap_en ? trap_pc : br_pc;

`ifdef TRAP_PC_ALIGN_EN
    assign target = {target_raw[63:2], 2'b00};
`else
    assign target = target_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            req_addr_reg <= RESET_PC;
            inst_reg     <= 32'd0;
            inst_pc_reg  <= 64'd0;
            flush_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_addr_reg <= req_addr_next;
            inst_reg     <= inst_next;
            inst_pc_reg  <= inst_pc_next;
            flush_reg    <= redirect;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        req_addr_next = req_addr_reg;
        inst_next     = inst_reg;
        inst_pc_next  = inst_pc_reg;

        case (state_reg)
            BOOT: begin
                // A late ack from before reset is ignored here: if_req is low.
                state_next = REQ;
                if (redirect) begin
                    pc_next       = target;
                    req_addr_next = target;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_next = target;
                    if (if_ack) begin
                        // Fetch done this cycle: drop it and go straight to the target.
                        req_addr_next = target;
                        state_next    = REQ;
                    end else begin
                        // Handshake must complete at the old address first.
                        state_next = DISCARD;
                    end
                end else if (if_ack) begin
                    inst_next    = if_rdata;
                    inst_pc_next = req_addr_reg;
                    pc_next      = req_addr_reg + 64'd4;
                    state_next   = VALID;
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_next       = target;
                    req_addr_next = target;
                    state_next    = REQ;
                end else if (!stall) begin
                    req_addr_next = pc_reg;
                    state_next    = REQ;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_next = target;
                end
                // The abandoned fetch completes: drop its data and fetch from
                // the newest target (this cycle's target if one arrives with
                // the ack).
                if (if_ack) begin
                    req_addr_next = redirect ? target : pc_reg;
                    state_next    = REQ;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign if_req     = (state_reg == REQ) || (state_reg == DISCARD);
    assign if_addr    = req_addr_reg;
    assign inst_valid = (state_reg == VALID);
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;
    assign flush      = flush_reg;

endmodule
